// File: rtl/spi_target.sv
// SPI mode-0 target with a 16-byte bus register window, one TX holding byte and an RX byte FIFO.
// Latency: bus ready/rdata one clk after the strobe; RX byte pushed within 1 clk of the 8th synchronized sclk rise.
// Backpressure: none on the bus; a full RX FIFO drops the incoming byte and sets rx_ovf. Optional macro: SPI_TARGET_IRQ_EN.
module spi_target #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_6000,
  parameter int          RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  input  logic        sclk_in,
  input  logic        cs_n_in,
  input  logic        mosi,
  output logic        miso
`ifdef SPI_TARGET_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int          AW       = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHIFT} state_t;

  state_t          r_state;
  logic [1:0]      r_sclk_sync;
  logic [1:0]      r_cs_sync;
  logic [1:0]      r_mosi_sync;
  logic            r_sclk_d;
  logic            r_cs_d;
  logic [7:0]      r_tx_shift;
  logic [7:0]      r_rx_shift;
  logic [2:0]      r_bit_cnt;
  logic            r_load_pend;
  logic [7:0]      r_tx_hold;
  logic            r_tx_free;
  logic            r_enable;
  logic            r_irq_en;
  logic            r_rx_ovf;
  logic [7:0]      r_mem [RX_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_ready;
  logic [31:0]     r_rdata;

  logic            w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_mosi;
  logic            w_active, w_wr, w_rd;
  logic [1:0]      w_reg;
  logic            w_data_wr, w_ovf_clr, w_ctrl_wr;
  logic            w_empty, w_full, w_pop, w_push, w_accept, w_drop;
  logic [7:0]      w_push_dat;
  logic            w_in_shift, w_frame_start, w_frame_end, w_byte_load, w_tx_take;
  logic [7:0]      w_tx_load_val;
  logic [31:0]     w_rd_mux;
  logic            w_unused;

  // Edge detection works on the synchronized samples only.
  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_d;
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_d;
  assign w_mosi      = r_mosi_sync[1];

  // Bus decode.
  assign w_active  = (addr[31:4] == BASE_ADDR[31:4]);
  assign active    = w_active;
  assign w_wr      = wen & w_active;
  assign w_rd      = ren & w_active;
  assign w_reg     = addr[3:2];
  assign w_data_wr = w_wr & (w_reg == 2'd0) & wmask[0] & r_tx_free;
  assign w_ovf_clr = w_wr & (w_reg == 2'd1) & wmask[0] & wdata[3];
  assign w_ctrl_wr = w_wr & (w_reg == 2'd2) & wmask[0];

  // FIFO handshake: a pop frees the slot a same-cycle push into a full FIFO needs.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = w_rd & (w_reg == 2'd0) & ~w_empty;
  assign w_in_shift = (r_state == S_SHIFT);
  assign w_frame_end   = w_in_shift & (w_cs_rise | ~r_enable);
  assign w_frame_start = (r_state == S_ARMED) & r_enable & w_cs_fall;
  assign w_push_dat = {r_rx_shift[6:0], w_mosi};
  assign w_push     = w_in_shift & ~w_frame_end & w_sclk_rise & (r_bit_cnt == 3'd7);
  assign w_accept   = w_push & (~w_full | w_pop);
  assign w_drop     = w_push & w_full & ~w_pop;

  // TX byte boundary: the pending load replaces the shift on the first fall after bit 8.
  assign w_byte_load   = w_in_shift & ~w_frame_end & w_sclk_fall & r_load_pend;
  assign w_tx_take     = (w_frame_start | w_byte_load) & ~r_tx_free;
  assign w_tx_load_val = r_tx_free ? 8'hFF : r_tx_hold;

  // TX_SHIFT idles at all-ones, so its MSB is the idle-high miso outside SHIFT.
  assign miso = r_tx_shift[7];

  assign w_unused = ^{addr[1:0], wdata[31:8], wmask[3:1]};

  // Two-flop synchronizers plus one delayed sample for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], sclk_in};
      r_cs_sync   <= {r_cs_sync[0], cs_n_in};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
      r_sclk_d    <= r_sclk_sync[1];
      r_cs_d      <= r_cs_sync[1];
    end
  end

  // Frame FSM with its shift registers and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tx_shift  <= 8'hFF;
      r_rx_shift  <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_load_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx_shift  <= 8'hFF;
          r_bit_cnt   <= 3'd0;
          r_load_pend <= 1'b0;
          if (r_enable) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (!r_enable) begin
            r_state <= S_IDLE;
          end else if (w_cs_fall) begin
            r_state     <= S_SHIFT;
            r_tx_shift  <= w_tx_load_val;
            r_bit_cnt   <= 3'd0;
            r_load_pend <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_frame_end) begin
            // A partial byte is simply abandoned: the counter restarts next frame.
            r_state     <= r_enable ? S_ARMED : S_IDLE;
            r_tx_shift  <= 8'hFF;
            r_bit_cnt   <= 3'd0;
            r_load_pend <= 1'b0;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shift <= w_push_dat;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_load_pend <= 1'b1;
            end
            if (w_sclk_fall) begin
              if (r_load_pend) begin
                r_tx_shift  <= w_tx_load_val;
                r_load_pend <= 1'b0;
              end else begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b1};
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // TX holding register: bus fills it, a byte boundary drains it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_hold <= 8'h00;
      r_tx_free <= 1'b1;
    end else if (w_data_wr) begin
      r_tx_hold <= wdata[7:0];
      r_tx_free <= 1'b0;
    end else if (w_tx_take) begin
      r_tx_free <= 1'b1;
    end
  end

  // Control register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_enable <= wdata[0];
`ifdef SPI_TARGET_IRQ_EN
      r_irq_en <= wdata[1];
`endif
    end
  end

  // Sticky overflow flag; a fresh drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_rx_ovf <= 1'b0;
    else if (w_drop)    r_rx_ovf <= 1'b1;
    else if (w_ovf_clr) r_rx_ovf <= 1'b0;
  end

  // RX FIFO storage.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_push_dat;
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_accept} - {{AW{1'b0}}, w_pop};
    end
  end

  // Read data mux.
  always_comb begin
    w_rd_mux = 32'h0;
    case (w_reg)
      2'd0: w_rd_mux = w_empty ? 32'h0 : {24'h0, r_mem[r_rd_ptr]};
      2'd1: w_rd_mux = {27'h0, w_in_shift, r_rx_ovf, r_tx_free, w_full, ~w_empty};
      2'd2: w_rd_mux = {30'h0, r_irq_en, r_enable};
      default: w_rd_mux = 32'h0;
    endcase
  end

  // Bus response, one cycle after the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_ready <= w_wr | w_rd;
      r_rdata <= w_rd ? w_rd_mux : 32'h0;
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;

`ifdef SPI_TARGET_IRQ_EN
  logic r_irq;
  // Level interrupt, registered from the FIFO/overflow state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= r_irq_en & (~w_empty | r_rx_ovf);
  end
  assign irq = r_irq;
`endif

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_6000: byte base address of the 16-byte register window.
REQ-002 Parameter RX_DEPTH, default 4: receive FIFO depth in bytes; legal values are powers of two from 2 to 16.
REQ-003 Port clk, input, 1: sole clock; every flop SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: reset; asynchronous, active-high.
REQ-005 Port addr, input, 32: bus byte address.
REQ-006 Port wdata, input, 32: bus write data.
REQ-007 Port wmask, input, 4: bus byte-lane write enables.
REQ-008 Port wen and port ren, each input, 1: bus write strobe and bus read strobe.
REQ-009 Port rdata, output, 32: bus read data.
REQ-010 Port ready, output, 1: bus access done.
REQ-011 Port active, output, 1: addr decodes to this block.
REQ-012 Port sclk_in, input, 1: SPI clock from the external controller; asynchronous to clk.
REQ-013 Port cs_n_in, input, 1: SPI chip select, active-low, asynchronous to clk.
REQ-014 Port mosi, input, 1: SPI data from the controller.
REQ-015 Port miso, output, 1: SPI data to the controller.

Function
REQ-016 active SHALL be combinational and high exactly when addr[31:4] equals BASE_ADDR[31:4].
REQ-017 ready SHALL pulse high for one cycle, in the cycle after (wen|ren)&active; it SHALL never assert without active.
REQ-018 Register map: 0x0 DATA; 0x4 STATUS; 0x8 CTRL; 0xC reads 0.
- DATA write, lane 0 only, loads TX_HOLD.
- DATA read returns the RX FIFO head in [7:0], zero-extended, and pops the FIFO; when the FIFO is empty it returns 0 and does not pop.
REQ-019 STATUS bits:
- [0] rx_nonempty; [1] rx_full; [2] tx_free; [3] rx_ovf (sticky; writing 1 clears it); [4] frame_active.
- All other bits read 0.
REQ-020 CTRL bits: [0] enable, read/write, reset value 0; [1] irq_en (REQ-036).
REQ-021 A DATA write while tx_free=0 SHALL be ignored, and ready SHALL still pulse.
REQ-022 sclk_in, cs_n_in and mosi SHALL each pass a 2-flop synchronizer; sclk edges SHALL be detected from the synchronized samples.
- Supported sclk is at most clk/4.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-023 FSM states: IDLE, ARMED, SHIFT.
- IDLE: enable=0; SPI inputs are ignored; miso=1.
- ARMED: enable=1 and waiting for a synchronized cs_n falling edge.
- SHIFT: entered on that edge; exits to ARMED on cs_n rising edge; exits to IDLE when enable is cleared.
REQ-024 Byte-boundary load: on entering SHIFT, and after each 8th bit, TX_SHIFT SHALL load TX_HOLD if tx_free=0 and then set tx_free=1; otherwise it SHALL load 8'hFF.
REQ-025 miso SHALL equal TX_SHIFT[7] in SHIFT and 1 otherwise; TX_SHIFT SHALL shift left on each synchronized sclk falling edge.
REQ-026 On each synchronized sclk rising edge in SHIFT, mosi SHALL shift into RX_SHIFT and the 3-bit bit counter SHALL increment.
REQ-027 The counter wrapping 7->0 SHALL push the completed byte into the RX FIFO within 1 clk of the 8th rising edge.
REQ-028 A push into a full FIFO SHALL drop the byte and set rx_ovf.
- A simultaneous bus pop and SPI push into a full FIFO SHALL both succeed, and rx_ovf SHALL stay unchanged.
REQ-029 cs_n rising mid-byte SHALL discard the partial byte without a push; the counter SHALL reset to 0.
REQ-030 The FIFO read and write pointers SHALL wrap modulo RX_DEPTH; an occupancy count of width log2(RX_DEPTH)+1 distinguishes full from empty.

Reset
REQ-031 On rst the block SHALL clear to these values:
- FSM IDLE, FIFO empty, rx_ovf=0, tx_free=1.
- TX_HOLD=0, TX_SHIFT=8'hFF, bit counter 0, CTRL=0.
- Synchronizers set to cs_n=1 and sclk=0.
REQ-032 Outputs during reset: ready=0, rdata=0, miso=1, irq=0.
REQ-033 Reset mid-frame SHALL abort the frame; with cs_n still low after reset and enable then set, no SHIFT SHALL occur until a new cs_n falling edge.

Configuration
REQ-034 Macro SPI_TARGET_IRQ_EN SHALL add an output port irq, 1 bit.
REQ-035 With SPI_TARGET_IRQ_EN defined, irq SHALL equal irq_en&(rx_nonempty|rx_ovf), registered, with 1 clk latency.
REQ-036 With SPI_TARGET_IRQ_EN defined, CTRL[1] irq_en SHALL be read/write; without the macro, the irq port SHALL be absent and CTRL[1] SHALL read 0 and ignore writes.

Verification
REQ-037 enable=1, TX_HOLD=8'hA5, controller sends 8'h3C at clk/8 -> miso bits 1,0,1,0,0,1,0,1; DATA reads 32'h3C; tx_free=1.
REQ-038 TX_HOLD not written, 2-byte frame -> controller receives 8'hFF twice; both MOSI bytes appear in the FIFO in order.
REQ-039 RX_DEPTH+1 bytes with no pops -> rx_full=1, rx_ovf=1, first RX_DEPTH bytes intact; writing 1 to STATUS[3] clears rx_ovf.
REQ-040 cs_n raised after 5 bits, then a full byte 8'h81 -> FIFO holds only 8'h81.
REQ-041 FIFO full, DATA read in the same cycle as a push -> no overflow, occupancy unchanged, order preserved.
REQ-042 With SPI_TARGET_IRQ_EN: irq_en=1, one byte received -> irq rises within 1 clk of the push and falls 1 clk after the pop empties the FIFO.
